// File: rtl/spike_layer.sv
// spike_layer: time-multiplexed rate-coded neuron layer on one serial pulse engine (clk, rst, start, pixels -> busy, done, neuron_out, balance_out, balance_valid, neuron_idx; SPIKE_LAYER_CLAMP_EN saturates balance at 0)
module spike_layer #(
  parameter int WIDTH = 8,
  parameter int HEIGHT = 7,
  parameter int NEURONS = 4,
  parameter int THRESHOLD = 0,
  parameter logic [NEURONS*HEIGHT*(WIDTH+1)-1:0] WEIGHTS = '0,
  localparam int BW = $clog2(HEIGHT*(2**WIDTH-1)+1)+1,
  localparam int NW = NEURONS > 1 ? $clog2(NEURONS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [HEIGHT-1:0]    pixels,
  output logic                 busy,
  output logic                 done,
  output logic [NEURONS-1:0]   neuron_out,
  output logic signed [BW-1:0] balance_out,
  output logic                 balance_valid,
  output logic [NW-1:0]        neuron_idx
);
  localparam int PW = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, EVAL = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic [HEIGHT-1:0] pix;
  logic [NW-1:0] nidx;
  logic [PW-1:0] pidx;
  logic [WIDTH-1:0] slot;
  logic signed [BW-1:0] bal, held, bal_next;
  logic [WIDTH:0] w;
  logic pulse;
  always_comb begin
    w = WEIGHTS[(int'(nidx)*HEIGHT+int'(pidx))*(WIDTH+1) +: WIDTH+1];
    pulse = pix[pidx] && (slot < w[WIDTH-1:0]);
`ifdef SPIKE_LAYER_CLAMP_EN
    bal_next = w[WIDTH] ? (bal == '0 ? bal : bal - BW'(1)) : bal + BW'(1);
`else
    bal_next = w[WIDTH] ? bal - BW'(1) : bal + BW'(1);
`endif
  end
  assign busy = state == RUN || state == EVAL;
  assign done = state == DONE;
  assign balance_valid = state == EVAL;
  assign balance_out = balance_valid ? bal : held;
  assign neuron_idx = nidx;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pix <= '0;
      nidx <= '0;
      pidx <= '0;
      slot <= '0;
      bal <= '0;
      held <= '0;
      neuron_out <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          pix <= pixels;
          neuron_out <= '0;
          bal <= '0;
          nidx <= '0;
          pidx <= '0;
          slot <= '0;
          state <= RUN;
        end
        RUN: begin
          slot <= slot + WIDTH'(1);
          if (pulse) bal <= bal_next;
          if (&slot) begin
            pidx <= pidx + PW'(1);
            if (pidx == PW'(HEIGHT-1)) state <= EVAL;
          end
        end
        EVAL: begin
          neuron_out[nidx] <= bal >= THRESHOLD;
          held <= bal;
          bal <= '0;
          pidx <= '0;
          if (nidx == NW'(NEURONS-1)) state <= DONE;
          else begin
            nidx <= nidx + NW'(1);
            state <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
